// File: rtl/dff_mem_arbiter_pkg.sv
// dff_mem_pkg: shared parameters, FSM state encoding and requester indices
// for the DFF PUF memory-port arbiter.
//   AW / DW / NB : default address width, data width and byte-lane count
//   state_t      : sequencer states (IDLE, ISSUE, WAIT, ACK)
//   REQ_HOST     : requester 0, the Wishbone host path
//   REQ_PUF      : requester 1, the PUF capture/readout engine
package dff_mem_pkg;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_PUF  = 1'b1;

  // Byte-lane write enables for a command. Reads never assert a lane.
  function automatic logic [NB-1:0] lane_we(input logic is_write, input logic [NB-1:0] sel);
    logic [NB-1:0] lanes;
    if (is_write) begin
      lanes = sel;
    end else begin
      lanes = {NB{1'b0}};
    end
    return lanes;
  endfunction

endpackage

// File: rtl/dff_mem_arbiter_if.sv
// dff_mem_arbiter_if: bundles both requester handshakes, the host_only/busy
// controls and the DFF memory port (WE/EN/Di/Do/A).
//   master : requester/memory side (drives req/cmd, host_only and Do)
//   slave  : arbiter side (drives ack/rdat, busy and the memory strobes)
interface dff_mem_arbiter_if;
  import dff_mem_pkg::*;

  logic          r0_req;
  logic          r0_we;
  logic [NB-1:0] r0_sel;
  logic [AW-1:0] r0_adr;
  logic [DW-1:0] r0_wdat;
  logic          r0_ack;
  logic [DW-1:0] r0_rdat;

  logic          r1_req;
  logic          r1_we;
  logic [NB-1:0] r1_sel;
  logic [AW-1:0] r1_adr;
  logic [DW-1:0] r1_wdat;
  logic          r1_ack;
  logic [DW-1:0] r1_rdat;

  logic          host_only;
  logic          busy;

  logic [NB-1:0] WE;
  logic          EN;
  logic [DW-1:0] Di;
  logic [DW-1:0] Do;
  logic [AW-1:0] A;

  modport master (
    output r0_req, r0_we, r0_sel, r0_adr, r0_wdat,
    output r1_req, r1_we, r1_sel, r1_adr, r1_wdat,
    output host_only, Do,
    input  r0_ack, r0_rdat, r1_ack, r1_rdat, busy,
    input  WE, EN, Di, A
  );

  modport slave (
    input  r0_req, r0_we, r0_sel, r0_adr, r0_wdat,
    input  r1_req, r1_we, r1_sel, r1_adr, r1_wdat,
    input  host_only, Do,
    output r0_ack, r0_rdat, r1_ack, r1_rdat, busy,
    output WE, EN, Di, A
  );

endinterface

// File: rtl/dff_mem_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin pick. The caller owns the
// last-grant register.
//   req[1:0]   : eligible requests (bit index = requester index)
//   last_grant : requester granted most recently
//   grant      : index of the winner (meaningful only with any_grant)
//   any_grant  : at least one request is eligible
module rr_arb2
  import dff_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       any_grant
);

  assign any_grant = |req;

  // Lone request wins outright; a tie goes to whoever was not served last.
  always_comb begin
    grant = REQ_HOST;
    case (req)
      2'b01:   grant = REQ_HOST;
      2'b10:   grant = REQ_PUF;
      2'b11:   grant = ~last_grant;
      default: grant = REQ_HOST;
    endcase
  end

endmodule

// File: rtl/dff_mem_arbiter.sv
// dff_mem_arbiter: shares the single DFF PUF memory port between the host
// path (requester 0) and the PUF engine (requester 1). Writes ack two cycles
// after the request edge, reads ack with data three cycles after it.
//   wb_clk_i  : clock, all logic on the rising edge
//   wb_rst_ni : synchronous active-low reset
//   bus       : requester handshakes, host_only/busy and the memory port
module dff_mem_arbiter
  import dff_mem_pkg::*;
(
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  dff_mem_arbiter_if.slave  bus
);

  state_t        state;
  logic          last_grant;
  logic          cmd_idx;
  logic          cmd_we;
  logic          mem_en;
  logic [NB-1:0] mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_di;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdat0;
  logic [DW-1:0] rdat1;
  logic          busy_flag;

  logic [1:0]    eligible;
  logic          grant;
  logic          any_grant;
  logic          win_we;
  logic [NB-1:0] win_sel;
  logic [AW-1:0] win_adr;
  logic [DW-1:0] win_wdat;

  assign eligible = {bus.r1_req & ~bus.host_only, bus.r0_req};

  rr_arb2 u_arb (
    .req        (eligible),
    .last_grant (last_grant),
    .grant      (grant),
    .any_grant  (any_grant)
  );

  // Route the winning requester's command to the latch point.
  always_comb begin
    win_we   = bus.r0_we;
    win_sel  = bus.r0_sel;
    win_adr  = bus.r0_adr;
    win_wdat = bus.r0_wdat;
    if (grant == REQ_PUF) begin
      win_we   = bus.r1_we;
      win_sel  = bus.r1_sel;
      win_adr  = bus.r1_adr;
      win_wdat = bus.r1_wdat;
    end else begin
      win_we   = bus.r0_we;
      win_sel  = bus.r0_sel;
      win_adr  = bus.r0_adr;
      win_wdat = bus.r0_wdat;
    end
  end

  // Sequencer FSM with all memory strobes, acks and read data registered.
  // A and Di are loaded at grant and double as the latched address/data,
  // so they hold through WAIT/ACK regardless of what the requester does.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state      <= IDLE;
      last_grant <= REQ_PUF;
      cmd_idx    <= REQ_HOST;
      cmd_we     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= {NB{1'b0}};
      mem_a      <= {AW{1'b0}};
      mem_di     <= {DW{1'b0}};
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdat0      <= {DW{1'b0}};
      rdat1      <= {DW{1'b0}};
      busy_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (any_grant) begin
            state     <= ISSUE;
            busy_flag <= 1'b1;
            cmd_idx   <= grant;
            cmd_we    <= win_we;
            mem_en    <= 1'b1;
            mem_we    <= lane_we(win_we, win_sel);
            mem_a     <= win_adr;
            mem_di    <= win_wdat;
          end else begin
            busy_flag <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= {NB{1'b0}};
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= {NB{1'b0}};
          if (cmd_we) begin
            // Writes skip WAIT: the ack goes out in the cycle after ISSUE.
            state <= ACK;
            ack0  <= (cmd_idx == REQ_HOST);
            ack1  <= (cmd_idx == REQ_PUF);
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // Do is valid now, one cycle after EN.
          if (cmd_idx == REQ_PUF) begin
            rdat1 <= bus.Do;
          end else begin
            rdat0 <= bus.Do;
          end
          state <= ACK;
          ack0  <= (cmd_idx == REQ_HOST);
          ack1  <= (cmd_idx == REQ_PUF);
        end
        ACK: begin
          ack0       <= 1'b0;
          ack1       <= 1'b0;
          last_grant <= cmd_idx;
          busy_flag  <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state     <= IDLE;
          mem_en    <= 1'b0;
          mem_we    <= {NB{1'b0}};
          ack0      <= 1'b0;
          ack1      <= 1'b0;
          busy_flag <= 1'b0;
        end
      endcase
    end
  end

  assign bus.EN      = mem_en;
  assign bus.WE      = mem_we;
  assign bus.A       = mem_a;
  assign bus.Di      = mem_di;
  assign bus.r0_ack  = ack0;
  assign bus.r1_ack  = ack1;
  assign bus.r0_rdat = rdat0;
  assign bus.r1_rdat = rdat1;
  assign bus.busy    = busy_flag;

endmodule

// File: tb/tb_dff_mem_arbiter.sv
// tb_dff_mem_arbiter: directed bench for dff_mem_arbiter with a behavioural
// byte-lane memory (Do registered one cycle after EN). Unwritten words read
// as {24'hA5A5A5, address}.
module tb_dff_mem_arbiter;
  import dff_mem_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   ho_acks;

  logic [DW-1:0] mem [0:255];

  dff_mem_arbiter_if bif ();

  dff_mem_arbiter dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preset on reset, byte-lane writes, registered read data.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= {24'hA5A5A5, 8'(i)};
    end else if (bif.EN) begin
      for (int b = 0; b < NB; b++) begin
        if (bif.WE[b]) mem[bif.A][b*8 +: 8] <= bif.Di[b*8 +: 8];
      end
      bif.Do <= mem[bif.A];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bif.host_only = 1'b0;
    bif.r0_req = 1'b0; bif.r0_we = 1'b0; bif.r0_sel = 4'h0; bif.r0_adr = 8'h00; bif.r0_wdat = 32'h0;
    bif.r1_req = 1'b0; bif.r1_we = 1'b0; bif.r1_sel = 4'h0; bif.r1_adr = 8'h00; bif.r1_wdat = 32'h0;
    step();
    step();
    chk("rst_en", bif.EN, 32'd0);
    chk("rst_we", bif.WE, 32'd0);
    chk("rst_a", bif.A, 32'd0);
    chk("rst_di", bif.Di, 32'd0);
    chk("rst_acks", {bif.r0_ack, bif.r1_ack}, 32'd0);
    chk("rst_r0_rdat", bif.r0_rdat, 32'd0);
    chk("rst_r1_rdat", bif.r1_rdat, 32'd0);
    chk("rst_busy", bif.busy, 32'd0);
    rst_n = 1'b1;

    // Single write from r0
    bif.r0_req = 1'b1; bif.r0_we = 1'b1; bif.r0_sel = 4'hF; bif.r0_adr = 8'h05; bif.r0_wdat = 32'hDEADBEEF;
    step();
    chk("wr_en", bif.EN, 32'd1);
    chk("wr_we", bif.WE, 32'hF);
    chk("wr_a", bif.A, 32'h05);
    chk("wr_di", bif.Di, 32'hDEADBEEF);
    chk("wr_busy", bif.busy, 32'd1);
    chk("wr_ack_early", bif.r0_ack, 32'd0);
    step();
    chk("wr_ack", bif.r0_ack, 32'd1);
    chk("wr_en_off", bif.EN, 32'd0);
    chk("wr_we_off", bif.WE, 32'd0);
    chk("wr_a_hold", bif.A, 32'h05);
    bif.r0_req = 1'b0;
    step();
    chk("wr_ack_pulse", bif.r0_ack, 32'd0);
    chk("wr_busy_idle", bif.busy, 32'd0);
    chk("wr_mem", mem[8'h05], 32'hDEADBEEF);

    // Single read from r1
    bif.r1_req = 1'b1; bif.r1_we = 1'b0; bif.r1_adr = 8'h05;
    step();
    chk("rd_en", bif.EN, 32'd1);
    chk("rd_we", bif.WE, 32'd0);
    chk("rd_a", bif.A, 32'h05);
    step();
    chk("rd_en_wait", bif.EN, 32'd0);
    chk("rd_ack_wait", bif.r1_ack, 32'd0);
    step();
    chk("rd_ack", bif.r1_ack, 32'd1);
    chk("rd_rdat", bif.r1_rdat, 32'hDEADBEEF);
    chk("rd_r0_rdat", bif.r0_rdat, 32'd0);
    chk("rd_r0_ack", bif.r0_ack, 32'd0);
    bif.r1_req = 1'b0;
    step();
    chk("rd_ack_pulse", bif.r1_ack, 32'd0);

    // Contention: both reading continuously, grants must alternate from r0
    bif.r0_req = 1'b1; bif.r0_we = 1'b0; bif.r0_adr = 8'h01;
    bif.r1_req = 1'b1; bif.r1_we = 1'b0; bif.r1_adr = 8'h02;
    for (int n = 0; n < 6; n++) begin
      int cnt;
      cnt = 0;
      do begin
        step();
        cnt++;
      end while (!(bif.r0_ack || bif.r1_ack) && cnt < 10);
      chk("cont_ack_seen", {31'd0, bif.r0_ack | bif.r1_ack}, 32'd1);
      chk("cont_latency", cnt, (n == 0) ? 32'd3 : 32'd4);
      chk("cont_r0_ack", bif.r0_ack, (n % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_r1_ack", bif.r1_ack, (n % 2 == 0) ? 32'd0 : 32'd1);
      if (n % 2 == 0) begin
        chk("cont_r0_rdat", bif.r0_rdat, 32'hA5A5A501);
      end else begin
        chk("cont_r1_rdat", bif.r1_rdat, 32'hA5A5A502);
      end
      if (n == 5) begin
        bif.r0_req = 1'b0;
        bif.r1_req = 1'b0;
      end
    end
    step();
    chk("cont_idle_busy", bif.busy, 32'd0);
    step();
    chk("cont_no_regrant", {bif.busy, bif.EN}, 32'd0);

    // host_only: r1 locked out while r0 keeps being served
    bif.host_only = 1'b1;
    bif.r0_req = 1'b1; bif.r0_we = 1'b1; bif.r0_sel = 4'b0011; bif.r0_adr = 8'h30; bif.r0_wdat = 32'h11223344;
    bif.r1_req = 1'b1; bif.r1_we = 1'b1; bif.r1_sel = 4'b0000; bif.r1_adr = 8'h31; bif.r1_wdat = 32'hFFFFFFFF;
    ho_acks = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("ho_r1_ack", bif.r1_ack, 32'd0);
      if (bif.r0_ack) ho_acks++;
    end
    chk("ho_r0_count", ho_acks, 32'd3);
    chk("ho_mem_lanes", mem[8'h30], 32'hA5A53344);
    bif.host_only = 1'b0;
    step();
    chk("ho_a", bif.A, 32'h31);
    chk("ho_en", bif.EN, 32'd1);
    chk("ho_sel0_we", bif.WE, 32'd0);
    step();
    chk("ho_r1_ack_now", bif.r1_ack, 32'd1);
    chk("ho_r0_ack_now", bif.r0_ack, 32'd0);
    bif.r0_req = 1'b0;
    bif.r1_req = 1'b0;
    step();
    chk("ho_mem_sel0", mem[8'h31], 32'hA5A5A531);
    chk("ho_busy", bif.busy, 32'd0);

    // Command change after grant: latched address wins, ack still pulses
    bif.r0_req = 1'b1; bif.r0_we = 1'b0; bif.r0_sel = 4'h0; bif.r0_adr = 8'h10;
    step();
    chk("cc_a", bif.A, 32'h10);
    chk("cc_en", bif.EN, 32'd1);
    bif.r0_adr = 8'h20;
    bif.r0_we = 1'b1;
    step();
    chk("cc_a_hold", bif.A, 32'h10);
    chk("cc_en_wait", bif.EN, 32'd0);
    chk("cc_we_wait", bif.WE, 32'd0);
    bif.r0_req = 1'b0;
    step();
    chk("cc_ack", bif.r0_ack, 32'd1);
    chk("cc_rdat", bif.r0_rdat, 32'hA5A5A510);
    step();
    chk("cc_busy", bif.busy, 32'd0);
    step();
    chk("cc_no_regrant", {bif.busy, bif.EN}, 32'd0);

    // Reset in the middle of a read
    bif.r0_req = 1'b1; bif.r0_we = 1'b0; bif.r0_adr = 8'h40;
    step();
    step();
    chk("mr_busy_wait", bif.busy, 32'd1);
    rst_n = 1'b0;
    bif.r1_req = 1'b1; bif.r1_we = 1'b0; bif.r1_adr = 8'h41;
    step();
    chk("mr_en", bif.EN, 32'd0);
    chk("mr_we", bif.WE, 32'd0);
    chk("mr_ack", {bif.r0_ack, bif.r1_ack}, 32'd0);
    chk("mr_busy", bif.busy, 32'd0);
    chk("mr_rdat_clr", bif.r0_rdat, 32'd0);
    rst_n = 1'b1;
    step();
    chk("mr_tie_a", bif.A, 32'h40);
    chk("mr_tie_en", bif.EN, 32'd1);
    step();
    step();
    chk("mr_r0_ack", bif.r0_ack, 32'd1);
    chk("mr_r1_ack", bif.r1_ack, 32'd0);
    chk("mr_rdat", bif.r0_rdat, 32'hA5A5A540);
    bif.r0_req = 1'b0;
    bif.r1_req = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
